// File: rtl/cpu_pipe_pkg.sv
// Shared types and constants for the CPU pipeline-stage registers.
// Stage occupancy encoding, per-stage default widths and the NOP instruction.
package cpu_pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } pstate_t;

  localparam int DEFAULT_WIDTH = 16;
  localparam int DEFAULT_CNT_W = 8;
  localparam int IFID_WIDTH    = 32;
  localparam int IDEX_WIDTH    = 32;
  localparam int EXMEM_WIDTH   = 32;
  localparam int MEMWB_WIDTH   = 32;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
// Shared by the pipeline perf/debug counters.
module sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)
      cnt_d = '0;
    else if (inc && (cnt_q != {CNT_W{1'b1}}))
      cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/pipe_stage_buf.sv
// Generic valid/ready pipeline-stage register with flush-to-NOP and a stall counter.
// SKID=1 uses a two-entry skid buffer so in_ready does not depend on out_ready.
module pipe_stage_buf
  import cpu_pipe_pkg::*;
#(
  parameter int               WIDTH     = DEFAULT_WIDTH,
  parameter int               SKID      = 1,
  parameter logic [WIDTH-1:0] NOP_VALUE = '0,
  parameter int               CNT_W     = DEFAULT_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic [CNT_W-1:0] stall_cnt,
  input  logic             clr_cnt
);

  logic             ready_w;
  logic             valid_w;
  logic [WIDTH-1:0] data_w;
  logic             accept;
  logic             out_fire;

  // A flush cycle never takes the incoming payload, even when ready is shown.
  assign accept   = in_valid & ready_w & ~flush;
  assign out_fire = valid_w & out_ready;

  if (SKID != 0) begin : g_skid
    pstate_t          state_q, state_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic [WIDTH-1:0] skid_q, skid_d;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_q <= EMPTY;
        main_q  <= NOP_VALUE;
        skid_q  <= NOP_VALUE;
      end else begin
        state_q <= state_d;
        main_q  <= main_d;
        skid_q  <= skid_d;
      end
    end

    always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      if (flush) begin
        state_d = EMPTY;
        main_d  = NOP_VALUE;
        skid_d  = NOP_VALUE;
      end else begin
        unique case (state_q)
          EMPTY: begin
            if (accept) begin
              state_d = ONE;
              main_d  = in_data;
            end
          end
          ONE: begin
            if (accept && !out_fire) begin
              state_d = TWO;
              skid_d  = in_data;
            end else if (!accept && out_fire) begin
              state_d = EMPTY;
            end else if (accept && out_fire) begin
              main_d  = in_data;
            end
          end
          TWO: begin
            if (out_fire) begin
              state_d = ONE;
              main_d  = skid_q;
            end
          end
          default: state_d = EMPTY;
        endcase
      end
    end

    always_comb begin
      ready_w = (state_q != TWO);
      valid_w = (state_q != EMPTY);
      data_w  = main_q;
    end
  end else begin : g_single
    logic             full_q, full_d;
    logic [WIDTH-1:0] data_q, data_d;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        full_q <= 1'b0;
        data_q <= NOP_VALUE;
      end else begin
        full_q <= full_d;
        data_q <= data_d;
      end
    end

    // When full and draining, a new payload simply replaces the departing one.
    always_comb begin
      full_d = full_q;
      data_d = data_q;
      if (flush) begin
        full_d = 1'b0;
        data_d = NOP_VALUE;
      end else if (accept) begin
        full_d = 1'b1;
        data_d = in_data;
      end else if (out_fire) begin
        full_d = 1'b0;
      end
    end

    always_comb begin
      ready_w = ~full_q | out_ready;
      valid_w = full_q;
      data_w  = data_q;
    end
  end

  assign in_ready  = ready_w;
  assign out_valid = valid_w;
  assign out_data  = valid_w ? data_w : NOP_VALUE;

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (valid_w & ~out_ready),
    .clr   (clr_cnt),
    .cnt   (stall_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Bench for pipe_stage_buf: a 16-bit skid-buffered stage and a 32-bit single-entry stage
// driven by the same upstream/downstream signals, each compared against its own queue model.
module tb_pipe_stage_buf;
  import cpu_pipe_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush, inValid, outReady, clrCnt;
  logic [31:0] inData;

  logic        aInReady, aOutValid;
  logic [15:0] aOutData;
  logic [3:0]  aStall;
  logic        bInReady, bOutValid;
  logic [31:0] bOutData;
  logic [7:0]  bStall;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // Reference model: occupancy, entries in FIFO order and stall count per stage.
  int          mCnt  [2];
  logic [31:0] mMem  [2][2];
  int          mSt   [2];
  int          mMax  [2];
  logic [31:0] mMask [2];
  logic [31:0] mNop  [2];

  typedef struct packed {
    logic        fl;
    logic        iv;
    logic [15:0] d;
    logic        ordy;
    logic        clr;
    logic        eRdy;
    logic        eVal;
    logic [15:0] eData;
    logic [3:0]  eSt;
  } vec_t;

  vec_t vecs [18];

  pipe_stage_buf #(.WIDTH(16), .SKID(1), .CNT_W(4)) dutA (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (inValid),
    .in_data   (inData[15:0]),
    .in_ready  (aInReady),
    .out_valid (aOutValid),
    .out_data  (aOutData),
    .out_ready (outReady),
    .stall_cnt (aStall),
    .clr_cnt   (clrCnt)
  );

  pipe_stage_buf #(.WIDTH(32), .SKID(0), .NOP_VALUE(NOP_INSTR), .CNT_W(8)) dutB (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (inValid),
    .in_data   (inData),
    .in_ready  (bInReady),
    .out_valid (bOutValid),
    .out_data  (bOutData),
    .out_ready (outReady),
    .stall_cnt (bStall),
    .clr_cnt   (clrCnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s @cyc %0d: actual=%h required=%h", name, cyc, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic fl, input logic iv, input logic [31:0] d,
                               input logic ordy, input logic clr);
    flush    = fl;
    inValid  = iv;
    inData   = d;
    outReady = ordy;
    clrCnt   = clr;
  endtask

  task automatic modelReset();
    for (int d = 0; d < 2; d++) begin
      mCnt[d] = 0;
      mSt[d]  = 0;
    end
  endtask

  task automatic checkOutput();
    for (int d = 0; d < 2; d++) begin
      logic        expV, expR;
      logic [31:0] expD;
      expV = (mCnt[d] > 0);
      expD = expV ? mMem[d][0] : mNop[d];
      expR = (d == 0) ? (mCnt[d] < 2) : ((mCnt[d] == 0) || outReady);
      if (d == 0) begin
        chk("A.in_ready",  {31'd0, aInReady},  {31'd0, expR});
        chk("A.out_valid", {31'd0, aOutValid}, {31'd0, expV});
        chk("A.out_data",  {16'd0, aOutData},  expD);
        chk("A.stall_cnt", {28'd0, aStall},    mSt[d]);
      end else begin
        chk("B.in_ready",  {31'd0, bInReady},  {31'd0, expR});
        chk("B.out_valid", {31'd0, bOutValid}, {31'd0, expV});
        chk("B.out_data",  bOutData,           expD);
        chk("B.stall_cnt", {24'd0, bStall},    mSt[d]);
      end
    end
  endtask

  task automatic modelUpdate();
    for (int d = 0; d < 2; d++) begin
      logic expV, expR, oFire, acc;
      expV  = (mCnt[d] > 0);
      expR  = (d == 0) ? (mCnt[d] < 2) : ((mCnt[d] == 0) || outReady);
      oFire = expV && outReady;
      acc   = inValid && expR && !flush;
      if (clrCnt)
        mSt[d] = 0;
      else if (expV && !outReady && (mSt[d] < mMax[d]))
        mSt[d]++;
      if (oFire) begin
        mMem[d][0] = mMem[d][1];
        mCnt[d]--;
      end
      if (flush)
        mCnt[d] = 0;
      else if (acc) begin
        mMem[d][mCnt[d]] = inData & mMask[d];
        mCnt[d]++;
      end
    end
  endtask

  task automatic finishCycle();
    @(posedge clk);
    modelUpdate();
    cyc++;
    #1;
  endtask

  task automatic runCycle();
    @(negedge clk);
    checkOutput();
    finishCycle();
  endtask

  initial begin
    mMax[0] = 15;       mMax[1] = 255;
    mMask[0] = 32'hFFFF; mMask[1] = 32'hFFFF_FFFF;
    mNop[0] = 32'h0;    mNop[1] = NOP_INSTR;
    modelReset();

    //                fl    iv    data      ordy  clr   eRdy  eVal  eData     eSt
    vecs[0]  = '{1'b0, 1'b1, 16'h000A, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 4'd0};
    vecs[1]  = '{1'b0, 1'b1, 16'h000B, 1'b0, 1'b0, 1'b1, 1'b1, 16'h000A, 4'd0};
    vecs[2]  = '{1'b0, 1'b1, 16'h000C, 1'b0, 1'b0, 1'b0, 1'b1, 16'h000A, 4'd1};
    vecs[3]  = '{1'b0, 1'b1, 16'h000C, 1'b0, 1'b0, 1'b0, 1'b1, 16'h000A, 4'd2};
    vecs[4]  = '{1'b0, 1'b1, 16'h000C, 1'b0, 1'b0, 1'b0, 1'b1, 16'h000A, 4'd3};
    vecs[5]  = '{1'b0, 1'b1, 16'h000C, 1'b0, 1'b0, 1'b0, 1'b1, 16'h000A, 4'd4};
    vecs[6]  = '{1'b0, 1'b1, 16'h000C, 1'b1, 1'b0, 1'b0, 1'b1, 16'h000A, 4'd5};
    vecs[7]  = '{1'b0, 1'b1, 16'h000C, 1'b1, 1'b0, 1'b1, 1'b1, 16'h000B, 4'd5};
    vecs[8]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b1, 16'h000C, 4'd5};
    vecs[9]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 4'd5};
    vecs[10] = '{1'b0, 1'b1, 16'h1111, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 4'd5};
    vecs[11] = '{1'b0, 1'b1, 16'h2222, 1'b0, 1'b0, 1'b1, 1'b1, 16'h1111, 4'd5};
    vecs[12] = '{1'b1, 1'b1, 16'hDEAD, 1'b0, 1'b0, 1'b0, 1'b1, 16'h1111, 4'd6};
    vecs[13] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 4'd7};
    vecs[14] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0000, 4'd7};
    vecs[15] = '{1'b0, 1'b1, 16'h3333, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 4'd0};
    vecs[16] = '{1'b1, 1'b1, 16'hDEAD, 1'b1, 1'b0, 1'b1, 1'b1, 16'h3333, 4'd0};
    vecs[17] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 4'd0};

    rst_n = 1'b0;
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst A.out_valid", {31'd0, aOutValid}, 32'd0);
    chk("rst A.in_ready",  {31'd0, aInReady},  32'd1);
    chk("rst B.out_data",  bOutData,           NOP_INSTR);
    chk("rst B.stall_cnt", {24'd0, bStall},    32'd0);
    rst_n = 1'b1;
    finishCycle();

    // Streaming 1..16 with no backpressure
    for (int k = 1; k <= 16; k++) begin
      applyStimulus(1'b0, 1'b1, k, 1'b1, 1'b0);
      @(negedge clk);
      chk("stream A.in_ready", {31'd0, aInReady}, 32'd1);
      if (k > 1) chk("stream A.out_data", {16'd0, aOutData}, k - 1);
      if (k > 1) chk("stream B.out_data", bOutData, k - 1);
      checkOutput();
      finishCycle();
    end
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    runCycle();
    runCycle();

    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
    runCycle();

    // Backpressure and flush corner cases from a known empty state
    for (int i = 0; i < 18; i++) begin
      applyStimulus(vecs[i].fl, vecs[i].iv, {16'h0, vecs[i].d}, vecs[i].ordy, vecs[i].clr);
      @(negedge clk);
      chk($sformatf("vec%0d A.in_ready", i),  {31'd0, aInReady},  {31'd0, vecs[i].eRdy});
      chk($sformatf("vec%0d A.out_valid", i), {31'd0, aOutValid}, {31'd0, vecs[i].eVal});
      chk($sformatf("vec%0d A.out_data", i),  {16'd0, aOutData},  {16'd0, vecs[i].eData});
      chk($sformatf("vec%0d A.stall_cnt", i), {28'd0, aStall},    {28'd0, vecs[i].eSt});
      checkOutput();
      finishCycle();
    end

    // Saturation: 20 stall cycles, then clear during a stall
    applyStimulus(1'b0, 1'b1, 32'h55, 1'b0, 1'b0);
    runCycle();
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    repeat (20) runCycle();
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    @(negedge clk);
    chk("sat A.stall_cnt", {28'd0, aStall}, 32'd15);
    chk("sat B.stall_cnt", {24'd0, bStall}, 32'd20);
    checkOutput();
    finishCycle();
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    @(negedge clk);
    chk("clr A.stall_cnt", {28'd0, aStall}, 32'd0);
    chk("clr B.stall_cnt", {24'd0, bStall}, 32'd0);
    checkOutput();
    finishCycle();
    runCycle();

    // Asynchronous reset with two entries held in the skid stage
    applyStimulus(1'b0, 1'b1, 32'h1, 1'b0, 1'b0);
    runCycle();
    applyStimulus(1'b0, 1'b1, 32'h2, 1'b0, 1'b0);
    runCycle();
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    chk("full A.in_ready", {31'd0, aInReady}, 32'd0);
    chk("full A.stall_cnt", {28'd0, aStall}, 32'd1);
    checkOutput();
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst A.out_valid", {31'd0, aOutValid}, 32'd0);
    chk("arst A.out_data",  {16'd0, aOutData},  32'd0);
    chk("arst A.stall_cnt", {28'd0, aStall},    32'd0);
    chk("arst A.in_ready",  {31'd0, aInReady},  32'd1);
    chk("arst B.out_valid", {31'd0, bOutValid}, 32'd0);
    chk("arst B.out_data",  bOutData,           NOP_INSTR);
    modelReset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    finishCycle();

    // Random traffic against the queue model
    for (int i = 0; i < 400; i++) begin
      applyStimulus($urandom_range(0, 99) < 5, $urandom_range(0, 99) < 70, $urandom,
                    $urandom_range(0, 99) < 60, $urandom_range(0, 99) < 3);
      runCycle();
    end
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    repeat (3) runCycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
